// File: rtl/sump_cmd_tx.sv
// SUMP host-side command serializer: sends a 1-byte short command or a
// 5-byte long command as 8N1 UART frames, with XOFF-style hold between bytes.
`timescale 1ns/1ps

module sump_cmd_tx #(
    parameter int FREQ     = 100000000,
    parameter int BAUDRATE = 115200,
    parameter int DIVISOR  = FREQ / BAUDRATE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [39:0] cmd,
    input  logic        pause,
    output logic        busy,
    output logic        done,
    output logic        uart_tx
);

    localparam int CW = (DIVISOR < 2) ? 1 : $clog2(DIVISOR);
    localparam logic [CW-1:0] BAUD_RELOAD = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] BAUD_ONE    = CW'(1);
    localparam logic [CW-1:0] BAUD_ZERO   = {CW{1'b0}};

    generate
        if (DIVISOR < 2) begin : g_divisor_check
            $error("sump_cmd_tx: DIVISOR must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CW-1:0]   baud_cnt_r;
    logic [CW-1:0]   baud_nxt_s;
    logic [2:0]      bit_idx_r;
    logic [2:0]      bit_nxt_s;
    logic [2:0]      bytes_left_r;
    logic [2:0]      bytes_nxt_s;
    logic [39:0]     cmd_r;
    logic [39:0]     cmd_nxt_s;
    logic [7:0]      tx_byte_s;
    logic            tx_nxt_s;
    logic            uart_tx_r;
    logic            done_nxt_s;
    logic            done_r;

    assign cmd_ready = (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);
    assign uart_tx   = uart_tx_r;
    assign done      = done_r;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath update; cmd_r shifts down one byte per completed frame.
    always_comb begin
        state_nxt_s = state_r;
        baud_nxt_s  = baud_cnt_r;
        bit_nxt_s   = bit_idx_r;
        bytes_nxt_s = bytes_left_r;
        cmd_nxt_s   = cmd_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_nxt_s   = cmd;
                    bytes_nxt_s = cmd[7] ? 3'd5 : 3'd1;
                    baud_nxt_s  = BAUD_RELOAD;
                    bit_nxt_s   = 3'd0;
                    state_nxt_s = pause ? ST_HOLD : ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_cnt_r == BAUD_ZERO) begin
                    baud_nxt_s  = BAUD_RELOAD;
                    bit_nxt_s   = 3'd0;
                    state_nxt_s = ST_DATA;
                end else begin
                    baud_nxt_s  = baud_cnt_r - BAUD_ONE;
                end
            end
            ST_DATA: begin
                if (baud_cnt_r == BAUD_ZERO) begin
                    baud_nxt_s = BAUD_RELOAD;
                    if (bit_idx_r == 3'd7) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        bit_nxt_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    baud_nxt_s = baud_cnt_r - BAUD_ONE;
                end
            end
            ST_STOP: begin
                if (baud_cnt_r == BAUD_ZERO) begin
                    bytes_nxt_s = bytes_left_r - 3'd1;
                    cmd_nxt_s   = {8'h00, cmd_r[39:8]};
                    baud_nxt_s  = BAUD_RELOAD;
                    bit_nxt_s   = 3'd0;
                    if (bytes_left_r == 3'd1) begin
                        done_nxt_s  = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else if (pause) begin
                        state_nxt_s = ST_HOLD;
                    end else begin
                        state_nxt_s = ST_START;
                    end
                end else begin
                    baud_nxt_s = baud_cnt_r - BAUD_ONE;
                end
            end
            ST_HOLD: begin
                if (!pause) begin
                    baud_nxt_s  = BAUD_RELOAD;
                    bit_nxt_s   = 3'd0;
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Line level for the coming cycle, derived from where the FSM is heading.
    always_comb begin
        tx_nxt_s  = 1'b1;
        tx_byte_s = cmd_nxt_s[7:0];
        case (state_nxt_s)
            ST_START: tx_nxt_s = 1'b0;
            ST_DATA:  tx_nxt_s = tx_byte_s[bit_nxt_s];
            default:  tx_nxt_s = 1'b1;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            baud_cnt_r   <= BAUD_ZERO;
            bit_idx_r    <= 3'd0;
            bytes_left_r <= 3'd0;
            cmd_r        <= 40'h00_0000_0000;
            uart_tx_r    <= 1'b1;
            done_r       <= 1'b0;
        end else begin
            baud_cnt_r   <= baud_nxt_s;
            bit_idx_r    <= bit_nxt_s;
            bytes_left_r <= bytes_nxt_s;
            cmd_r        <= cmd_nxt_s;
            uart_tx_r    <= tx_nxt_s;
            done_r       <= done_nxt_s;
        end
    end

endmodule

// File: tb/tb_sump_cmd_tx.sv
// Bench for sump_cmd_tx: per-cycle line model built from frame sample queues,
// a mid-bit UART decoder, a vector table and hand-written corner sequences.
`timescale 1ns/1ps

module tb_sump_cmd_tx;

    localparam int DIV = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [39:0] cmd = 40'h0;
    logic        pause = 1'b0;
    logic        cmd_ready;
    logic        busy;
    logic        done;
    logic        uart_tx;

    int total = 0;
    int bad = 0;

    sump_cmd_tx #(.FREQ(1000000), .BAUDRATE(100000)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .pause(pause), .busy(busy), .done(done), .uart_tx(uart_tx)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: the line as a queue of per-clock levels for the current frame.
    logic        mq[$];
    logic [7:0]  mbytes[$];
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    logic        s_valid, s_pause;
    logic [39:0] s_cmd;

    always @(posedge clock) begin
        s_valid <= cmd_valid;
        s_pause <= pause;
        s_cmd   <= cmd;
    end

    function automatic void m_frame(input logic [7:0] b);
        logic lvl;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) lvl = 1'b0;
            else if (i == 9) lvl = 1'b1;
            else lvl = b[i-1];
            for (int k = 0; k < DIV; k++) mq.push_back(lvl);
        end
    endfunction

    function automatic void m_step();
        m_done = 1'b0;
        if (!m_busy) begin
            if (s_valid) begin
                mbytes.delete();
                mbytes.push_back(s_cmd[7:0]);
                if (s_cmd[7]) begin
                    for (int i = 1; i < 5; i++) mbytes.push_back(s_cmd[8*i +: 8]);
                end
                m_busy = 1'b1;
                if (!s_pause) m_frame(mbytes.pop_front());
            end
        end else if (mq.size() > 0) begin
            void'(mq.pop_front());
            if (mq.size() == 0) begin
                if (mbytes.size() == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end else if (!s_pause) begin
                    m_frame(mbytes.pop_front());
                end
            end
        end else if (!s_pause) begin
            m_frame(mbytes.pop_front());
        end
    endfunction

    // Decoder state
    logic        rx_act = 1'b0;
    int          rx_cnt = 0;
    int          rx_k;
    logic [7:0]  rx_byte = 8'h00;
    logic [7:0]  rx_q[$];
    logic [3:0]  exp_v;

    always @(negedge clock) begin
        if (!reset) begin
            mq.delete();
            mbytes.delete();
            m_busy = 1'b0;
            m_done = 1'b0;
            rx_act = 1'b0;
        end else begin
            m_step();
            if (!rx_act) begin
                if (uart_tx == 1'b0) begin
                    rx_act = 1'b1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt == DIV/2) begin
                    if (uart_tx) rx_act = 1'b0;
                end else if (rx_cnt > DIV/2 && ((rx_cnt - DIV/2) % DIV) == 0) begin
                    rx_k = (rx_cnt - DIV/2) / DIV;
                    if (rx_k <= 8) begin
                        rx_byte[rx_k-1] = uart_tx;
                    end else begin
                        check("stop_bit", uart_tx, 1);
                        rx_q.push_back(rx_byte);
                        rx_act = 1'b0;
                    end
                end
            end
        end
        exp_v = {(mq.size() > 0) ? mq[0] : 1'b1, m_busy, m_done, ~m_busy};
        check("cycle_tx_busy_done_ready", {uart_tx, busy, done, cmd_ready}, exp_v);
    end

    function automatic logic [39:0] rx_pack();
        logic [39:0] v = 40'h0;
        for (int i = 0; i < rx_q.size() && i < 5; i++) v[8*i +: 8] = rx_q[i];
        return v;
    endfunction

    function automatic logic [39:0] exp_pack(input logic [39:0] c);
        return c[7] ? c : {32'h0, c[7:0]};
    endfunction

    task automatic send(input logic [39:0] c);
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd = c;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        cmd = {8'($urandom), 32'($urandom)};
    endtask

    task automatic wait_done(input int limit, input bit rnd, output int cycles);
        cycles = 0;
        while (cycles < limit) begin
            @(posedge clock);
            #1;
            cycles++;
            if (rnd) pause = ($urandom_range(0, 3) == 0);
            if (done) break;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    typedef struct {
        logic [39:0] cmd;
        int          cycles;
        int          nbytes;
        int          hold;
    } vec_t;

    vec_t vecs[7];
    int   c;
    int   elapsed;
    logic [39:0] rc;

    initial begin
        vecs[0] = '{40'h00_0000_0001, 100, 1, 0};
        vecs[1] = '{40'h12_3456_78C0, 500, 5, 0};
        vecs[2] = '{40'h00_0000_007F, 100, 1, 0};
        vecs[3] = '{40'hFF_FFFF_FFFF, 500, 5, 0};
        vecs[4] = '{40'hDE_ADBE_EF02, 100, 1, 0};
        vecs[5] = '{40'hA5_A5A5_A580, 503, 5, 3};
        vecs[6] = '{40'h00_0000_0055, 107, 1, 7};

        // Reset state
        @(negedge clock);
        #3;
        check("rst_tx", uart_tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", cmd_ready, 1);
        reset = 1'b1;

        foreach (vecs[i]) begin
            rx_q.delete();
            pause = (vecs[i].hold > 0);
            send(vecs[i].cmd);
            elapsed = 0;
            if (vecs[i].hold > 0) begin
                tick(vecs[i].hold - 1);
                pause = 1'b0;
                elapsed = vecs[i].hold - 1;
            end
            wait_done(2000, 1'b0, c);
            check("vec_cycles", elapsed + c, vecs[i].cycles);
            check("vec_count", rx_q.size(), vecs[i].nbytes);
            check("vec_data", rx_pack(), exp_pack(vecs[i].cmd));
        end

        // Flow control: pause during byte 2, held 37 clocks past its stop
        rx_q.delete();
        send(40'h12_3456_78C0);
        tick(150);
        pause = 1'b1;
        tick(86);
        check("hold_line_high", uart_tx, 1);
        check("hold_busy", busy, 1);
        pause = 1'b0;
        tick(1);
        check("hold_resume_start", uart_tx, 0);
        wait_done(2000, 1'b0, c);
        check("hold_cycles", 237 + c, 537);
        check("hold_data", rx_pack(), 40'h12_3456_78C0);

        // Busy rejection
        rx_q.delete();
        send(40'h89_ABCD_EFA1);
        tick(40);
        cmd_valid = 1'b1;
        cmd = 40'h00_0000_0001;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("busy_ready_low", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        wait_done(2000, 1'b0, c);
        check("busy_cycles", 45 + c, 500);
        check("busy_data", rx_pack(), 40'h89_ABCD_EFA1);

        // Back-to-back with cmd_valid held
        rx_q.delete();
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd = 40'h00_0000_0011;
        tick(1);
        cmd = 40'h00_0000_0022;
        wait_done(2000, 1'b0, c);
        check("b2b_first_cycles", c, 100);
        check("b2b_ready_in_done", cmd_ready, 1);
        tick(1);
        check("b2b_second_busy", busy, 1);
        check("b2b_second_start", uart_tx, 0);
        cmd_valid = 1'b0;
        wait_done(2000, 1'b0, c);
        check("b2b_second_cycles", c, 100);
        check("b2b_count", rx_q.size(), 2);
        check("b2b_data", rx_pack(), 40'h00_0000_2211);

        // Randomized commands with random pause
        for (int t = 0; t < 30; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clock);
            rc = {32'($urandom), 8'($urandom)};
            rx_q.delete();
            send(rc);
            wait_done(3000, 1'b1, c);
            pause = 1'b0;
            check("rnd_done", done, 1);
            check("rnd_count", rx_q.size(), rc[7] ? 5 : 1);
            check("rnd_data", rx_pack(), exp_pack(rc));
        end

        // Reset during byte 3 data
        pause = 1'b0;
        send(40'h12_3400_78C3);
        tick(250);
        check("pre_rst_tx_low", uart_tx, 0);
        check("pre_rst_busy", busy, 1);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_tx", uart_tx, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_ready", cmd_ready, 1);
        check("async_rst_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst_no_done", done, 0);
        end
        rx_q.delete();
        @(negedge clock);
        #2;
        reset = 1'b1;
        cmd_valid = 1'b1;
        cmd = 40'h00_0000_003C;
        tick(1);
        check("post_rst_accept", busy, 1);
        cmd_valid = 1'b0;
        wait_done(2000, 1'b0, c);
        check("post_rst_cycles", c, 100);
        check("post_rst_data", rx_pack(), 40'h00_0000_003C);

        tick(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sump_cmd_tx.md
SUMP_CMD_TX -- requirements
Module: sump_cmd_tx

Interface
REQ-001 SHALL have parameter FREQ, default 100000000, meaning the system clock frequency in Hz.
REQ-002 SHALL have parameter BAUDRATE, default 115200, meaning the serial bit rate.
REQ-003 SHALL have derived parameter DIVISOR, default FREQ/BAUDRATE (integer divide), meaning the clocks per serial bit; DIVISOR < 2 SHALL be an elaboration error.
REQ-004 SHALL have one clock, `clock`, and an asynchronous active-low reset, `reset`:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have the following data and status ports:
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  block can accept a command.
- cmd  input  40  command as {opdata[31:0], opcode[7:0]}.
- pause  input  1  flow-control hold (XOFF state); high = no new byte may start.
- busy  output  1  a command is in progress.
- done  output  1  one-cycle pulse when a command's final stop bit completes.
- uart_tx  output  1  serial line, 8N1, LSB first, idle high.

Function
REQ-006 SHALL serialize SUMP host commands, the counterpart of the device-side command receiver.
- opcode[7]=0: short command, 1 byte (opcode).
- opcode[7]=1: long command, 5 bytes in order opcode, opdata[7:0], opdata[15:8], opdata[23:16], opdata[31:24].
REQ-007 SHALL run an FSM with states IDLE, START, DATA, STOP, HOLD.
REQ-008 SHALL drive cmd_ready=1 only in IDLE; a handshake is cmd_valid&&cmd_ready at a rising edge.
REQ-009 On handshake, SHALL register cmd, set the byte count (1 or 5 per REQ-006), and enter START on the next cycle.
REQ-010 cmd_valid outside IDLE SHALL be ignored; there is no queue, and cmd changes after the handshake SHALL NOT affect the transfer.
REQ-011 Per-state line level and duration, DIVISOR clocks each, timed by a baud counter of $clog2(DIVISOR) bits that reloads at each bit boundary:
- START: uart_tx=0 for DIVISOR clocks.
- DATA: 8 bits, LSB first, DIVISOR clocks each.
- STOP: uart_tx=1 for DIVISOR clocks.
REQ-012 At the end of STOP with bytes remaining:
- pause=0: go to START directly, with no inter-byte gap.
- pause=1: go to HOLD.
REQ-013 HOLD SHALL keep uart_tx=1 and go to START on the first cycle pause is sampled low; pause SHALL NOT interrupt a byte already started.
REQ-014 pause SHALL NOT block acceptance of a command in IDLE; the first byte SHALL obey pause exactly as REQ-012 and REQ-013, going to HOLD instead of START if pause=1.
REQ-015 At the end of the last STOP, SHALL return to IDLE and pulse done=1 for exactly one cycle, the first cycle in IDLE.
REQ-016 busy SHALL equal (state != IDLE); uart_tx and done SHALL be registered outputs.
REQ-017 Timing:
- Short-command line time SHALL be 10*DIVISOR clocks.
- Long-command line time SHALL be 50*DIVISOR clocks with pause=0.
- A new handshake is possible in the same cycle done pulses.

Reset
REQ-018 Asserting reset at any time, including mid-byte, SHALL immediately force:
- state=IDLE;
- uart_tx=1, busy=0, done=0, cmd_ready=1;
- all counters and the command register to 0.
REQ-019 No handshake SHALL occur while reset is low; after reset release the block SHALL accept a command on the first rising edge.

Verification (FREQ=1000000, BAUDRATE=100000, DIVISOR=10)
REQ-020 Short command:
- Stimulus: cmd=40'h00_0000_0001 handshake.
- Response: uart_tx low 10 clocks, then bits 1,0,0,0,0,0,0,0, then high 10 clocks.
- done pulses 100 clocks after START entry; busy high throughout.
REQ-021 Long command:
- Stimulus: cmd={32'h12345678, 8'hC0}, pause=0.
- Response: bytes C0,78,56,34,12 back-to-back; done at clock 500; decoding uart_tx recovers the same cmd.
REQ-022 Flow control:
- Stimulus: long command; pause raised mid byte 2 and held 37 clocks past its STOP.
- Response: byte 2 completes intact; line high for the hold; byte 3 START begins 1 clock after pause falls; total time 500+37 clocks.
REQ-023 Busy rejection: cmd_valid pulsed with a different cmd during a transfer -> ignored; serialized bytes unchanged; cmd_ready=0 throughout.
REQ-024 Reset mid-operation:
- Stimulus: reset low during DATA of byte 3.
- Response: uart_tx=1 asynchronously (before the next clock edge); busy=0; no done pulse.
- After release, a new short command serializes correctly.
REQ-025 Back-to-back: cmd_valid held high with two commands presented in sequence -> second handshake occurs in the done cycle; START of the second command follows the first STOP with at most 1 idle clock.
